// File: rtl/rvfi_trace_buffer.sv
// Retirement trace FIFO: buffers retired instruction/PC pairs for a slow consumer,
// counting entries that had to be dropped and every retirement seen.
module rvfi_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     trs_valid,
    input  logic [31:0]              trs_instr,
    input  logic [XLEN-1:0]          trs_pc,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [63:0]              retire_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [31:0]     instrMem [DEPTH];
    logic [XLEN-1:0] pcMem    [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   dropCount_q, dropCount_d;
    logic [63:0]   retireCount_q, retireCount_d;
    logic          doPush, doPop, doDrop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        doPop         = (level_q != '0) && out_ready;
        doPush        = trs_valid && ((level_q != FULL_LEVEL) || doPop);
        doDrop        = trs_valid && !doPush;
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        level_d       = level_q;
        overflow_d    = overflow_q;
        dropCount_d   = dropCount_q;
        retireCount_d = retireCount_q + 64'(trs_valid);
        if (clr) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            dropCount_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + 1'b1;
            if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
            if (doPush && !doPop) begin
                level_d = level_q + 1'b1;
            end else if (doPop && !doPush) begin
                level_d = level_q - 1'b1;
            end
            if (doDrop) begin
                overflow_d = 1'b1;
                if (dropCount_q != 16'hFFFF) dropCount_d = dropCount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            dropCount_q   <= '0;
            retireCount_q <= '0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            dropCount_q   <= dropCount_d;
            retireCount_q <= retireCount_d;
        end
    end

    // Storage has no reset; pointers alone define which slots are live.
    always_ff @(posedge clock) begin
        if (doPush && !clr && !reset) begin
            instrMem[wrPtr_q] <= trs_instr;
            pcMem[wrPtr_q]    <= trs_pc;
        end
    end

    assign out_valid    = (level_q != '0);
    assign out_instr    = instrMem[rdPtr_q];
    assign out_pc       = pcMem[rdPtr_q];
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign drop_count   = dropCount_q;
    assign retire_count = retireCount_q;

endmodule
